mem_iface: RTL and testbench
============================

MEM_IFACE -- requirements
Module: mem_iface

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, memory address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter TIMEOUT, default 8, maximum request cycles before abort (range 2..15).
REQ-004 clk  in  1  single clock; all state on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 ld_mar  in  1  load MAR from addr_in.
REQ-007 ld_mdr  in  1  load MDR from data_in.
REQ-008 oe_mar  in  1  drive MAR onto addr_out.
REQ-009 oe_mdr  in  1  drive MDR onto data_out.
REQ-010 mem_rd / mem_wr  in  1 each  start read / write access.
REQ-011 clr_fault  in  1  clear sticky fault.
REQ-012 addr_in  in  ADDR_W  and  data_in  in  DATA_W  internal bus values.
REQ-013 addr_out  out  ADDR_W  and  data_out  out  DATA_W  bus drive, zero when not enabled.
REQ-014 busy  out  1  access in progress; done  out  1  one-cycle completion pulse; fault  out  1  sticky error.
REQ-015 m_addr  out  ADDR_W,  m_wdata  out  DATA_W,  m_req  out  1,  m_we  out  1  memory request side.
REQ-016 m_rdata  in  DATA_W,  m_ack  in  1  memory response side.

Function
REQ-017 FSM SHALL have states IDLE, RD, WR, DONE; busy = (RD or WR); done = DONE; m_req = busy; m_we = WR.
REQ-018 In IDLE, mem_rd=1 and mem_wr=0 at an edge SHALL enter RD; mem_wr=1 and mem_rd=0 SHALL enter WR.
REQ-019 In IDLE, mem_rd=1 and mem_wr=1 together SHALL start no access, set fault, and enter DONE.
REQ-020 m_addr SHALL equal MAR and m_wdata SHALL equal MDR at all times.
REQ-021 In RD, an edge with m_ack=1 SHALL load MDR from m_rdata and enter DONE; in WR, m_ack=1 SHALL enter DONE.
REQ-022 A wait counter SHALL clear on entering RD/WR and increment each busy cycle without ack; at count TIMEOUT-1 without ack it SHALL set fault, leave MDR unchanged, and enter DONE.
REQ-023 m_ack and timeout on the same edge: ack SHALL win, fault unchanged.
REQ-024 DONE SHALL last exactly one cycle, ignore mem_rd/mem_wr, and return to IDLE.
REQ-025 Minimum access: request sampled edge N, m_req high cycle N+1, with zero-wait ack done high cycle N+2.
REQ-026 ld_mar/ld_mdr SHALL take effect only when not busy; ignored while busy.
REQ-027 ld_mdr in IDLE SHALL load data_in; an ld_mdr concurrent with the RD ack edge SHALL be ignored (memory data wins).
REQ-028 addr_out/data_out SHALL be combinational: MAR/MDR when oe_mar/oe_mdr is high, else zero.
REQ-029 m_ack outside RD/WR SHALL be ignored.
REQ-030 fault SHALL clear on clr_fault when not being set the same edge; set wins over clear.

Reset
REQ-031 rst SHALL asynchronously force IDLE, MAR=0, MDR=0, counter=0, fault=0; hence busy=done=m_req=m_we=0.
REQ-032 rst mid-access SHALL drop m_req immediately with no MDR update.

Structure
REQ-033 State encodings (2-bit) and default ADDR_W/DATA_W SHALL live in the shared CPU definitions header, used by control as well.
REQ-034 The wait counter with terminal-count output SHALL be a sub-module named wait_timer.

Verification
REQ-035 MAR=0x0010, mem_rd, ack after 3 wait cycles with m_rdata=0xDEADBEEF -> busy 4 cycles, done pulse, MDR=0xDEADBEEF, fault=0.
REQ-036 MAR=0x0020, MDR=0x12345678, mem_wr, zero-wait ack -> m_we=1 with m_addr=0x0020, m_wdata=0x12345678 one cycle, done next cycle.
REQ-037 mem_rd with m_ack never asserted, TIMEOUT=8 -> busy exactly 8 cycles, fault=1, MDR unchanged; clr_fault -> fault=0.
REQ-038 mem_rd and mem_wr together -> no m_req, fault=1, done one cycle.
REQ-039 rst asserted during cycle 2 of a read -> m_req low in that cycle, state IDLE, MDR=0.
REQ-040 ld_mar with addr_in=0x00FF during busy -> MAR unchanged; oe_mar low -> addr_out=0.

Source files
------------

// File: rtl/mem_iface_pkg.sv
// mem_iface_pkg: shared state encodings and default widths for the CPU memory interface
package mem_iface_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 32;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/mem_iface_if.sv
// mem_iface_if: request/response bus between mem_iface and external memory
interface mem_iface_if #(
    parameter int ADDR_W = mem_iface_pkg::DEF_ADDR_W,
    parameter int DATA_W = mem_iface_pkg::DEF_DATA_W
);

    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;
    logic              m_req;
    logic              m_we;
    logic              m_ack;

    modport master (output m_addr, m_wdata, m_req, m_we, input m_rdata, m_ack);
    modport slave  (input m_addr, m_wdata, m_req, m_we, output m_rdata, m_ack);

endinterface

// File: rtl/mem_iface_wait_timer.sv
// wait_timer: counts unacknowledged access cycles, flags the last allowed one
module wait_timer import mem_iface_pkg::*; #(
    parameter int TIMEOUT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst)
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 1'b1;

    assign tc = cnt == CNT_W'(TIMEOUT - 1);

endmodule

// File: rtl/mem_iface.sv
// mem_iface: MAR/MDR bus interface with read/write memory handshake, timeout and sticky fault
module mem_iface import mem_iface_pkg::*; #(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_mar,
    input  logic              ld_mdr,
    input  logic              oe_mar,
    input  logic              oe_mdr,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic              clr_fault,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] data_in,
    output logic [ADDR_W-1:0] addr_out,
    output logic [DATA_W-1:0] data_out,
    output logic              busy,
    output logic              done,
    output logic              fault,
    mem_iface_if.master       mem
);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] mar;
    logic [DATA_W-1:0] mdr;
    logic              tc;
    logic              set_fault;

    // counter runs only while busy and is held at zero otherwise, so it starts fresh per access
    wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk (clk),
        .rst (rst),
        .clr (!busy),
        .en  (busy && !mem.m_ack),
        .tc  (tc)
    );

    always_ff @(posedge clk or posedge rst)
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;

    always_comb begin
        state_nxt = state;
        set_fault = 1'b0;
        unique case (state)
            IDLE: begin
                set_fault = mem_rd && mem_wr;
                state_nxt = mem_rd && mem_wr ? DONE : mem_rd ? RD : mem_wr ? WR : IDLE;
            end
            RD, WR: begin
                set_fault = tc && !mem.m_ack;
                state_nxt = tc || mem.m_ack ? DONE : state;
            end
            DONE: state_nxt = IDLE;
        endcase
    end

    // memory read data has priority over a bus load of MDR
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            mar   <= '0;
            mdr   <= '0;
            fault <= 1'b0;
        end else begin
            if (ld_mar && !busy)
                mar <= addr_in;
            if (state == RD && mem.m_ack)
                mdr <= mem.m_rdata;
            else if (ld_mdr && !busy)
                mdr <= data_in;
            fault <= set_fault || (fault && !clr_fault);
        end

    assign busy        = state == RD || state == WR;
    assign done        = state == DONE;
    assign mem.m_req   = busy;
    assign mem.m_we    = state == WR;
    assign mem.m_addr  = mar;
    assign mem.m_wdata = mdr;
    assign addr_out    = oe_mar ? mar : '0;
    assign data_out    = oe_mdr ? mdr : '0;

endmodule

// File: tb/tb_mem_iface.sv
// tb_mem_iface: directed and randomized checks of mem_iface against a transaction-level model
`timescale 1ns/1ps
module tb_mem_iface;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ld_mar = 0, ld_mdr = 0, oe_mar = 0, oe_mdr = 0;
    logic          mem_rd = 0, mem_wr = 0, clr_fault = 0;
    logic [AW-1:0] addr_in = '0;
    logic [DW-1:0] data_in = '0;
    logic [AW-1:0] addr_out;
    logic [DW-1:0] data_out;
    logic          busy, done, fault;
    logic          ack = 1'b0;
    logic [DW-1:0] rdata = '0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_iface_if #(.ADDR_W(AW), .DATA_W(DW)) mem ();
    assign mem.m_ack   = ack;
    assign mem.m_rdata = rdata;

    mem_iface #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .ld_mar    (ld_mar),
        .ld_mdr    (ld_mdr),
        .oe_mar    (oe_mar),
        .oe_mdr    (oe_mdr),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .clr_fault (clr_fault),
        .addr_in   (addr_in),
        .data_in   (data_in),
        .addr_out  (addr_out),
        .data_out  (data_out),
        .busy      (busy),
        .done      (done),
        .fault     (fault),
        .mem       (mem)
    );

    // transaction-level model: an access is either in flight (with its age) or finishing
    logic [AW-1:0] mar_m;
    logic [DW-1:0] mdr_m;
    bit            fault_m, act_m, wr_m, done_m;
    int            waited;

    task automatic model_reset();
        mar_m = '0; mdr_m = '0; fault_m = 0; act_m = 0; wr_m = 0; done_m = 0; waited = 0;
    endtask

    task automatic model_step();
        bit sf = 0;
        if (!act_m) begin
            if (ld_mar) mar_m = addr_in;
            if (ld_mdr) mdr_m = data_in;
        end
        if (done_m)
            done_m = 0;
        else if (act_m) begin
            if (ack) begin
                if (!wr_m) mdr_m = rdata;
                act_m = 0; done_m = 1;
            end else if (waited == TO - 1) begin
                sf = 1; act_m = 0; done_m = 1;
            end else
                waited++;
        end else if (mem_rd && mem_wr) begin
            sf = 1; done_m = 1;
        end else if (mem_rd || mem_wr) begin
            act_m = 1; wr_m = mem_wr; waited = 0;
        end
        fault_m = sf || (fault_m && !clr_fault);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_step();
        #2;
    endtask

    always @(negedge clk) begin
        chk("busy",     64'(busy),         64'(act_m));
        chk("done",     64'(done),         64'(done_m));
        chk("fault",    64'(fault),        64'(fault_m));
        chk("m_req",    64'(mem.m_req),    64'(act_m));
        chk("m_we",     64'(mem.m_we),     64'(act_m && wr_m));
        chk("m_addr",   64'(mem.m_addr),   64'(mar_m));
        chk("m_wdata",  64'(mem.m_wdata),  64'(mdr_m));
        chk("addr_out", 64'(addr_out),     64'(oe_mar ? mar_m : '0));
        chk("data_out", 64'(data_out),     64'(oe_mdr ? mdr_m : '0));
    end

    initial begin
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_busy", 64'(busy), 0);
        chk("rst_m_req", 64'(mem.m_req), 0);
        tick();
        rst = 1'b0;

        // read with three wait cycles
        ld_mar = 1; addr_in = 16'h0010; tick();
        ld_mar = 0; mem_rd = 1; tick();
        mem_rd = 0; rdata = 32'hDEADBEEF;
        for (int i = 0; i < 4; i++) begin
            ack = (i == 3);
            @(negedge clk); chk("rd_busy", 64'(busy), 1);
            tick();
        end
        ack = 0; oe_mdr = 1;
        @(negedge clk);
        chk("rd_done", 64'(done), 1);
        chk("rd_mdr", 64'(data_out), 64'h0000_0000_DEAD_BEEF);
        chk("rd_fault", 64'(fault), 0);
        tick();

        // zero-wait write
        ld_mar = 1; addr_in = 16'h0020; ld_mdr = 1; data_in = 32'h12345678; tick();
        ld_mar = 0; ld_mdr = 0; mem_wr = 1; tick();
        mem_wr = 0; ack = 1;
        @(negedge clk);
        chk("wr_we", 64'(mem.m_we), 1);
        chk("wr_addr", 64'(mem.m_addr), 64'h0020);
        chk("wr_wdata", 64'(mem.m_wdata), 64'h1234_5678);
        tick();
        ack = 0;
        @(negedge clk); chk("wr_done", 64'(done), 1);
        tick();

        // read that never gets an ack
        mem_rd = 1; tick();
        mem_rd = 0;
        for (int i = 0; i < TO; i++) begin
            @(negedge clk); chk("to_busy", 64'(busy), 1);
            tick();
        end
        @(negedge clk);
        chk("to_busy_off", 64'(busy), 0);
        chk("to_fault", 64'(fault), 1);
        chk("to_mdr", 64'(data_out), 64'h1234_5678);
        tick();
        clr_fault = 1; tick();
        clr_fault = 0;
        @(negedge clk); chk("to_clr", 64'(fault), 0);

        // conflicting read and write
        mem_rd = 1; mem_wr = 1; tick();
        mem_rd = 0; mem_wr = 0;
        @(negedge clk);
        chk("both_req", 64'(mem.m_req), 0);
        chk("both_fault", 64'(fault), 1);
        chk("both_done", 64'(done), 1);
        tick();
        @(negedge clk); chk("both_done_off", 64'(done), 0);
        clr_fault = 1; tick();
        clr_fault = 0;

        // reset in the second cycle of a read
        mem_rd = 1; tick();
        mem_rd = 0; tick();
        rst = 1; model_reset();
        #1;
        chk("rst_mid_req", 64'(mem.m_req), 0);
        @(negedge clk);
        chk("rst_mid_mdr", 64'(data_out), 0);
        chk("rst_mid_busy", 64'(busy), 0);
        tick();
        rst = 0;

        // ld_mar ignored while busy, addr_out gated by oe_mar
        ld_mar = 1; addr_in = 16'h0030; tick();
        ld_mar = 0; mem_rd = 1; tick();
        mem_rd = 0; ld_mar = 1; addr_in = 16'h00FF; oe_mar = 0; tick();
        ld_mar = 0;
        @(negedge clk);
        chk("busy_mar", 64'(mem.m_addr), 64'h0030);
        chk("oe_mar_off", 64'(addr_out), 0);
        ack = 1; rdata = 32'hCAFE0001; tick();
        ack = 0; tick();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 399) == 0);
            if (rst) model_reset();
            ld_mar    = ($urandom_range(0, 3) == 0);
            ld_mdr    = ($urandom_range(0, 3) == 0);
            oe_mar    = $urandom_range(0, 1);
            oe_mdr    = $urandom_range(0, 1);
            mem_rd    = ($urandom_range(0, 4) == 0);
            mem_wr    = ($urandom_range(0, 4) == 0);
            clr_fault = ($urandom_range(0, 7) == 0);
            ack       = ($urandom_range(0, 3) == 0);
            addr_in   = AW'($urandom);
            data_in   = $urandom;
            rdata     = $urandom;
            tick();
        end
        rst = 0;
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
